// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit type, constants and FSM state encoding for bcd_addsub_seq.
package bcd_pkg;
  typedef logic [3:0] bcd_digit_t;
  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam logic [4:0] BCD_ADJ = 5'd6;
  typedef enum logic [1:0] {IDLE, CALC, FIX, FIN} state_t;
  function automatic bcd_digit_t nines(input bcd_digit_t d);
    return BCD_MAX - d;
  endfunction
endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add: combinational single-digit BCD add with carry in/out.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  output bcd_digit_t sum,
  output logic       cout
);
  logic [4:0] s;
  assign s    = {1'b0, a} + {1'b0, b} + {4'b0, cin};
  assign cout = s > 5'd9;
  assign sum  = cout ? 4'(s + BCD_ADJ) : s[3:0];
endmodule

// File: rtl/bcd_addsub_seq.sv
// bcd_addsub_seq: digit-serial N_DIG BCD adder/subtractor with start/busy/done handshake.
// Define BCD_SUB_EN to enable subtraction (op_sub, FIX state, negative flag).
module bcd_addsub_seq
  import bcd_pkg::*;
#(
  parameter int N_DIG = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   op_sub,
  input  logic [4*N_DIG-1:0]     a_bcd,
  input  logic [4*N_DIG-1:0]     b_bcd,
  output logic                   busy,
  output logic                   done,
  output logic [4*(N_DIG+1)-1:0] result,
  output logic                   negative,
  output logic                   invalid
);
  localparam int IW = $clog2(N_DIG + 1);
  localparam logic [IW-1:0] LAST = IW'(N_DIG - 1);
  state_t             state;
  logic [IW-1:0]      idx;
  logic [4*N_DIG-1:0] a_r, b_r, b_nine;
  logic               carry, sub_r, sub_in, bad, cout;
  bcd_digit_t         da, db, sum;
`ifdef BCD_SUB_EN
  assign sub_in = op_sub;
`else
  logic unused_op;
  assign unused_op = op_sub;
  assign sub_in    = 1'b0;
`endif
  always_comb begin
    bad    = 1'b0;
    b_nine = '0;
    for (int i = 0; i < N_DIG; i++) begin
      bad |= (a_bcd[4*i+:4] > BCD_MAX) | (b_bcd[4*i+:4] > BCD_MAX);
      b_nine[4*i+:4] = nines(b_bcd[4*i+:4]);
    end
  end
  // FIX reuses the adder as (9 - digit) + carry to form the ten's complement
  always_comb begin
    da = state == FIX ? nines(result[4*idx+:4]) : a_r[4*idx+:4];
    db = state == FIX ? 4'd0 : b_r[4*idx+:4];
  end
  bcd_digit_add u_add (
    .a   (da),
    .b   (db),
    .cin (carry),
    .sum (sum),
    .cout(cout)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      negative <= 1'b0;
      invalid  <= 1'b0;
      idx      <= '0;
      carry    <= 1'b0;
      sub_r    <= 1'b0;
      a_r      <= '0;
      b_r      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a_r      <= a_bcd;
          b_r      <= sub_in ? b_nine : b_bcd;
          sub_r    <= sub_in;
          carry    <= sub_in;
          result   <= '0;
          negative <= 1'b0;
          invalid  <= bad;
          idx      <= '0;
          busy     <= 1'b1;
          done     <= bad;
          state    <= bad ? FIN : CALC;
        end
        CALC: begin
          result[4*idx+:4] <= sum;
          carry            <= cout;
          idx              <= idx + 1'b1;
          if (idx == LAST) begin
            idx <= '0;
`ifdef BCD_SUB_EN
            if (sub_r && !cout) begin
              negative <= 1'b1;
              carry    <= 1'b1;
              state    <= FIX;
            end else
`endif
            begin
              result[4*N_DIG+:4] <= {3'b0, cout & ~sub_r};
              done               <= 1'b1;
              state              <= FIN;
            end
          end
        end
`ifdef BCD_SUB_EN
        FIX: begin
          result[4*idx+:4] <= sum;
          carry            <= cout;
          idx              <= idx + 1'b1;
          if (idx == LAST) begin
            idx   <= '0;
            done  <= 1'b1;
            state <= FIN;
          end
        end
`endif
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
